// File: rtl/player_pkg.sv
// Shared types and constants for the per-player movement/animation sequencer.
package player_pkg;

  localparam int CELL_SIZE = 32;
  localparam int CELL_BITS = 5;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_QUERY,
    ST_MOVE,
    ST_DEAD
  } state_t;

  localparam logic [2:0] SPR_FRONT_IDLE = 3'd0;
  localparam logic [2:0] SPR_FRONT_WALK = 3'd1;
  localparam logic [2:0] SPR_BACK_IDLE  = 3'd2;
  localparam logic [2:0] SPR_BACK_WALK  = 3'd3;
  localparam logic [2:0] SPR_SIDE_LEFT  = 3'd4;
  localparam logic [2:0] SPR_SIDE_RIGHT = 3'd5;
  localparam logic [2:0] SPR_DEAD       = 3'd6;

  // Facing down shows the front of the sprite, facing up shows its back.
  function automatic logic [2:0] idle_sprite(input dir_t facing);
    case (facing)
      DIR_UP:    return SPR_BACK_IDLE;
      DIR_LEFT:  return SPR_SIDE_LEFT;
      DIR_RIGHT: return SPR_SIDE_RIGHT;
      default:   return SPR_FRONT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/player_anim.sv
// Walk-animation counter and sprite selection; instantiated by player_ctrl only
// when PLAYER_CTRL_ANIM_EN is defined.
module player_anim
  import player_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       moving,
  input  logic       dead,
  input  dir_t       facing,
  output logic [2:0] sprite_num
);

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alt_q, alt_d;
  logic [2:0]       sprite_q, sprite_d;
  logic             walk;

  always_comb begin
    cnt_d = cnt_q;
    alt_d = alt_q;
    if (!moving) begin
      cnt_d = '0;
      alt_d = 1'b0;
    end else if (frame_tick) begin
      if (cnt_q == CNT_W'(ANIM_DIV - 1)) begin
        cnt_d = '0;
        alt_d = ~alt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // alt_q low selects the walk image so a fresh move starts on walk.
    walk = moving && !alt_d;
    case (facing)
      DIR_UP:    sprite_d = walk ? SPR_BACK_WALK : SPR_BACK_IDLE;
      DIR_DOWN:  sprite_d = walk ? SPR_FRONT_WALK : SPR_FRONT_IDLE;
      DIR_LEFT:  sprite_d = SPR_SIDE_LEFT;
      default:   sprite_d = SPR_SIDE_RIGHT;
    endcase
    if (dead) sprite_d = SPR_DEAD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      alt_q    <= 1'b0;
      sprite_q <= SPR_FRONT_IDLE;
    end else begin
      cnt_q    <= cnt_d;
      alt_q    <= alt_d;
      sprite_q <= sprite_d;
    end
  end

  assign sprite_num = sprite_q;

endmodule

// File: rtl/player_ctrl.sv
// Per-frame player movement sequencer with wall lookup through a req/ack port.
// Optional walk animation is enabled by defining PLAYER_CTRL_ANIM_EN.
module player_ctrl
  import player_pkg::*;
#(
  parameter int START_X    = 32,
  parameter int START_Y    = 32,
  parameter int MIN_CELL_X = 1,
  parameter int MAX_CELL_X = 18,
  parameter int MIN_CELL_Y = 1,
  parameter int MAX_CELL_Y = 13,
  parameter int STEP       = 4,
  parameter int ANIM_DIV   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  input  logic       respawn,
  output logic       map_req,
  output logic [4:0] map_cellX,
  output logic [4:0] map_cellY,
  input  logic       map_ack,
  input  logic       map_wall,
  output logic [9:0] player_centerX,
  output logic [9:0] player_centerY,
  output logic [2:0] sprite_num,
  output logic       moving,
  output logic       overrun
);

  state_t         state_q, state_d;
  logic [9:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  dir_t           dir_q, dir_d, face_q, face_d;
  logic [4:0]     tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic           map_req_q, map_req_d;
  logic           moving_q, moving_d;
  logic           overrun_q, overrun_d;

  logic           aligned, any_btn, oob;
  dir_t           req_dir;
  int             tx, ty;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dir_d     = dir_q;
    face_d    = face_q;
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    map_req_d = 1'b0;
    overrun_d = overrun_q ||
                (frame_tick && state_q != ST_IDLE && state_q != ST_DEAD);

    aligned = (pos_x_q[CELL_BITS-1:0] == '0) && (pos_y_q[CELL_BITS-1:0] == '0);
    any_btn = btn_up || btn_down || btn_left || btn_right;
    if (btn_up)        req_dir = DIR_UP;
    else if (btn_down) req_dir = DIR_DOWN;
    else if (btn_left) req_dir = DIR_LEFT;
    else               req_dir = DIR_RIGHT;

    tx = int'(pos_x_q[9:CELL_BITS]);
    ty = int'(pos_y_q[9:CELL_BITS]);
    case (req_dir)
      DIR_UP:    ty = ty - 1;
      DIR_DOWN:  ty = ty + 1;
      DIR_LEFT:  tx = tx - 1;
      default:   tx = tx + 1;
    endcase
    oob = (tx < MIN_CELL_X) || (tx > MAX_CELL_X) ||
          (ty < MIN_CELL_Y) || (ty > MAX_CELL_Y);

    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (!aligned) begin
          state_d = ST_MOVE;
        end else if (!any_btn) begin
          state_d = ST_IDLE;
        end else begin
          dir_d  = req_dir;
          face_d = req_dir;
          if (oob) begin
            state_d = ST_IDLE;
          end else begin
            tgt_x_d   = tx[CELL_BITS-1:0];
            tgt_y_d   = ty[CELL_BITS-1:0];
            map_req_d = 1'b1;
            state_d   = ST_QUERY;
          end
        end
      end
      ST_QUERY: begin
        if (map_ack) state_d = map_wall ? ST_IDLE : ST_MOVE;
        else         map_req_d = 1'b1;
      end
      ST_MOVE: begin
        case (dir_q)
          DIR_UP:    pos_y_d = pos_y_q - 10'(STEP);
          DIR_DOWN:  pos_y_d = pos_y_q + 10'(STEP);
          DIR_LEFT:  pos_x_d = pos_x_q - 10'(STEP);
          default:   pos_x_d = pos_x_q + 10'(STEP);
        endcase
        state_d = ST_IDLE;
      end
      ST_DEAD: begin
        if (respawn) begin
          pos_x_d = 10'(START_X);
          pos_y_d = 10'(START_Y);
          face_d  = DIR_DOWN;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A hit freezes the player where it stands and abandons any pending lookup.
    if (hit && state_q != ST_DEAD) begin
      state_d   = ST_DEAD;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      map_req_d = 1'b0;
    end

    moving_d = (pos_x_d[CELL_BITS-1:0] != '0) || (pos_y_d[CELL_BITS-1:0] != '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pos_x_q   <= 10'(START_X);
      pos_y_q   <= 10'(START_Y);
      dir_q     <= DIR_DOWN;
      face_q    <= DIR_DOWN;
      tgt_x_q   <= '0;
      tgt_y_q   <= '0;
      map_req_q <= 1'b0;
      moving_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dir_q     <= dir_d;
      face_q    <= face_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      map_req_q <= map_req_d;
      moving_q  <= moving_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef PLAYER_CTRL_ANIM_EN
  player_anim #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .moving     (moving_d),
    .dead       (state_d == ST_DEAD),
    .facing     (face_d),
    .sprite_num (sprite_num)
  );
`else
  logic [2:0] sprite_q, sprite_d;

  always_comb begin
    sprite_d = (state_d == ST_DEAD) ? SPR_DEAD : idle_sprite(face_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sprite_q <= SPR_FRONT_IDLE;
    else          sprite_q <= sprite_d;
  end

  assign sprite_num = sprite_q;
`endif

  assign map_req        = map_req_q;
  assign map_cellX      = tgt_x_q;
  assign map_cellY      = tgt_y_q;
  assign player_centerX = pos_x_q;
  assign player_centerY = pos_y_q;
  assign moving         = moving_q;
  assign overrun        = overrun_q;

endmodule
